// File: rtl/omr_pkg.sv
// Shared types and helpers for the OMR stream grader and the result/display logic.
package omr_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, GRADE, DONE} state_t;

    typedef enum logic [1:0] {BLANK, CORRECT, WRONG} class_t;

    // Width needed to hold a count from 0 up to and including numQ.
    function automatic int cntWidth(input int numQ);
        return $clog2(numQ + 1);
    endfunction

endpackage

// File: rtl/omr_stream_grader_if.sv
// One-beat-per-question answer stream between the sheet reader and the grader.
interface omr_stream_grader_if #(
    parameter int OPT_W = 4
);
    logic             ans_valid;
    logic [OPT_W-1:0] ans_data;
    logic             ans_ready;

    modport master (output ans_valid, output ans_data, input ans_ready);
    modport slave  (input ans_valid, input ans_data, output ans_ready);
endinterface

// File: rtl/omr_key_store.sv
// Answer key register array: one synchronous write port, one asynchronous read port.
module omr_key_store #(
    parameter int NUM_Q = 10,
    parameter int OPT_W = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OPT_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [OPT_W-1:0] o_rd_data
);

    logic [OPT_W-1:0] r_key [NUM_Q];

    // Decoded per-entry writes keep the index width independent of the array depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_Q; i++) r_key[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_key[i] <= i_wr_data;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (i_rd_idx == IDX_W'(i)) o_rd_data = r_key[i];
        end
    end

endmodule

// File: rtl/omr_stream_grader.sv
// Loads an answer key over a valid/ready stream, then grades student sheets against it
// with negative marking, a zero floor and saturation at the score width.
module omr_stream_grader
    import omr_pkg::*;
#(
    parameter int NUM_Q    = 10,
    parameter int OPT_W    = 4,
    parameter int POS_MARK = 1,
    parameter int NEG_MARK = 1,
    parameter int SCORE_W  = 8,
    localparam int CNT_W   = cntWidth(NUM_Q)
) (
    input  logic                clk,
    input  logic                reset,
    omr_stream_grader_if.slave  ans,
    input  logic                i_key_load,
    input  logic                i_grade_start,
    output logic                o_key_loaded,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_correct_cnt,
    output logic [CNT_W-1:0]    o_wrong_cnt,
    output logic [CNT_W-1:0]    o_blank_cnt,
    output logic [SCORE_W-1:0]  o_score
);

    localparam int RAW_W = 64;
    localparam logic signed [RAW_W-1:0] POS_WIDE  = RAW_W'(POS_MARK);
    localparam logic signed [RAW_W-1:0] NEG_WIDE  = RAW_W'(NEG_MARK);
    localparam logic signed [RAW_W-1:0] SCORE_MAX = (64'sd1 <<< SCORE_W) - 64'sd1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_correctCnt;
    logic [CNT_W-1:0]   r_wrongCnt;
    logic [CNT_W-1:0]   r_blankCnt;
    logic [SCORE_W-1:0] r_score;
    logic               r_keyLoaded;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    logic [OPT_W-1:0]        w_keyData;
    logic                    w_accept;
    logic                    w_keyWr;
    logic                    w_lastIdx;
    logic                    w_sheetEnd;
    class_t                  w_class;
    logic signed [RAW_W-1:0] w_raw;
    logic [SCORE_W-1:0]      w_score;

    assign w_accept   = ans.ans_valid && r_ready;
    assign w_keyWr    = w_accept && (r_state == LOAD);
    assign w_lastIdx  = (r_idx == CNT_W'(NUM_Q - 1));
    assign w_sheetEnd = (r_idx == CNT_W'(NUM_Q));

    omr_key_store #(
        .NUM_Q (NUM_Q),
        .OPT_W (OPT_W),
        .IDX_W (CNT_W)
    ) u_keyStore (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_keyWr),
        .i_wr_idx  (r_idx),
        .i_wr_data (ans.ans_data),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_keyData)
    );

    // Blank is tested first so a zero key entry never turns a blank into a correct.
    always_comb begin
        w_class = WRONG;
        if (ans.ans_data == '0) begin
            w_class = BLANK;
        end else if (ans.ans_data == w_keyData) begin
            w_class = CORRECT;
        end
    end

    always_comb begin
        w_raw   = $signed(RAW_W'(r_correctCnt)) * POS_WIDE - $signed(RAW_W'(r_wrongCnt)) * NEG_WIDE;
        w_score = w_raw[SCORE_W-1:0];
        if (w_raw[RAW_W-1]) begin
            w_score = '0;
        end else if (w_raw > SCORE_MAX) begin
            w_score = '1;
        end
    end

    // In GRADE the index runs one past the last question; that extra cycle turns the
    // final registered tallies into the score before entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_correctCnt <= '0;
            r_wrongCnt   <= '0;
            r_blankCnt   <= '0;
            r_score      <= '0;
            r_keyLoaded  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_key_load) begin
                        r_state     <= LOAD;
                        r_idx       <= '0;
                        r_keyLoaded <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b1;
                    end else if (i_grade_start && r_keyLoaded) begin
                        r_state      <= GRADE;
                        r_idx        <= '0;
                        r_correctCnt <= '0;
                        r_wrongCnt   <= '0;
                        r_blankCnt   <= '0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_ready      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_lastIdx) begin
                            r_state     <= IDLE;
                            r_idx       <= '0;
                            r_keyLoaded <= 1'b1;
                            r_busy      <= 1'b0;
                            r_ready     <= 1'b0;
                        end else begin
                            r_idx <= r_idx + CNT_W'(1);
                        end
                    end
                end
                GRADE: begin
                    if (w_sheetEnd) begin
                        r_state <= DONE;
                        r_score <= w_score;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        case (w_class)
                            BLANK:   r_blankCnt   <= r_blankCnt + CNT_W'(1);
                            CORRECT: r_correctCnt <= r_correctCnt + CNT_W'(1);
                            default: r_wrongCnt   <= r_wrongCnt + CNT_W'(1);
                        endcase
                        r_idx <= r_idx + CNT_W'(1);
                        if (w_lastIdx) r_ready <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ans.ans_ready  = r_ready;
    assign o_key_loaded   = r_keyLoaded;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_correct_cnt  = r_correctCnt;
    assign o_wrong_cnt    = r_wrongCnt;
    assign o_blank_cnt    = r_blankCnt;
    assign o_score        = r_score;

endmodule

// File: tb/tb_omr_stream_grader.sv
// Randomised bench for omr_stream_grader: a default-marking instance and a POS_MARK=30
// instance share one stimulus stream and are checked against a tally-and-clamp model.
module tb_omr_stream_grader;
   import omr_pkg::*;

   localparam int NUM_Q   = 10;
   localparam int OPT_W   = 4;
   localparam int SCORE_W = 8;
   localparam int CNT_W   = cntWidth(NUM_Q);
   localparam int POS_B   = 30;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic keyLoad = 1'b0;
   logic gradeStart = 1'b0;
   logic beatValid = 1'b0;
   logic [OPT_W-1:0] beatData = '0;

   logic keyLoadedA, busyA, doneA, keyLoadedB, busyB, doneB;
   logic [CNT_W-1:0] correctA, wrongA, blankA, correctB, wrongB, blankB;
   logic [SCORE_W-1:0] scoreA, scoreB;

   int compareCount = 0;
   int mismatchCount = 0;

   logic [OPT_W-1:0] modelKey [NUM_Q];
   logic [OPT_W-1:0] sheet [NUM_Q];

   always #5 clk = ~clk;

   omr_stream_grader_if #(.OPT_W(OPT_W)) ifA ();
   omr_stream_grader_if #(.OPT_W(OPT_W)) ifB ();

   assign ifA.ans_valid = beatValid;
   assign ifA.ans_data  = beatData;
   assign ifB.ans_valid = beatValid;
   assign ifB.ans_data  = beatData;

   omr_stream_grader #(.NUM_Q(NUM_Q), .OPT_W(OPT_W), .POS_MARK(1), .NEG_MARK(1), .SCORE_W(SCORE_W)) dutA (
      .clk(clk), .reset(reset), .ans(ifA.slave), .i_key_load(keyLoad), .i_grade_start(gradeStart),
      .o_key_loaded(keyLoadedA), .o_busy(busyA), .o_done(doneA), .o_correct_cnt(correctA),
      .o_wrong_cnt(wrongA), .o_blank_cnt(blankA), .o_score(scoreA)
   );

   omr_stream_grader #(.NUM_Q(NUM_Q), .OPT_W(OPT_W), .POS_MARK(POS_B), .NEG_MARK(1), .SCORE_W(SCORE_W)) dutB (
      .clk(clk), .reset(reset), .ans(ifB.slave), .i_key_load(keyLoad), .i_grade_start(gradeStart),
      .o_key_loaded(keyLoadedB), .o_busy(busyB), .o_done(doneB), .o_correct_cnt(correctB),
      .o_wrong_cnt(wrongB), .o_blank_cnt(blankB), .o_score(scoreB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int clampScore(input int correct, input int wrong, input int pos, input int neg);
      int raw;
      raw = correct * pos - wrong * neg;
      if (raw < 0) return 0;
      if (raw > (1 << SCORE_W) - 1) return (1 << SCORE_W) - 1;
      return raw;
   endfunction

   task automatic checkIdleAfterReset();
      checkOutput("rstKeyLoaded", keyLoadedA, 0);
      checkOutput("rstBusy", busyA, 0);
      checkOutput("rstDone", doneA, 0);
      checkOutput("rstReady", ifA.ans_ready, 0);
      checkOutput("rstCorrect", correctA, 0);
      checkOutput("rstWrong", wrongA, 0);
      checkOutput("rstBlank", blankA, 0);
      checkOutput("rstScore", scoreA, 0);
   endtask

   // Issues one command then streams the current sheet; resetAt aborts after that beat.
   task automatic applyStimulus(input bit isKey, input bit withGaps, input bit bothCmds,
                                input int startAt, input int resetAt);
      int waitCycles;
      int expC, expW, expB;
      if (isKey || bothCmds) keyLoad = 1'b1;
      if (!isKey || bothCmds) gradeStart = 1'b1;
      @(posedge clk); #1;
      keyLoad = 1'b0;
      gradeStart = 1'b0;
      checkOutput("busyAfterCmd", busyA, 1);
      checkOutput("readyAfterCmd", ifA.ans_ready, 1);
      if (isKey) checkOutput("keyLoadedDrops", keyLoadedA, 0);
      for (int q = 0; q < NUM_Q; q++) begin
         if (withGaps) begin
            repeat ($urandom_range(2, 0)) begin
               beatValid = 1'b0;
               beatData = OPT_W'($urandom);
               @(posedge clk); #1;
            end
         end
         beatValid = 1'b1;
         beatData = sheet[q];
         if (q == startAt) gradeStart = 1'b1;
         waitCycles = 0;
         while (!ifA.ans_ready && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
         end
         if (waitCycles >= 20) begin
            checkOutput("readyTimeout", 0, 1);
            beatValid = 1'b0;
            gradeStart = 1'b0;
            return;
         end
         @(posedge clk); #1;
         gradeStart = 1'b0;
         if (q == resetAt) begin
            beatValid = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            for (int i = 0; i < NUM_Q; i++) modelKey[i] = '0;
            checkIdleAfterReset();
            return;
         end
      end
      beatValid = 1'b0;
      if (isKey) begin
         for (int i = 0; i < NUM_Q; i++) modelKey[i] = sheet[i];
         checkOutput("keyLoadedSet", keyLoadedA, 1);
         checkOutput("loadBusyDone", busyA, 0);
         checkOutput("loadReadyDone", ifA.ans_ready, 0);
      end else begin
         expC = 0; expW = 0; expB = 0;
         for (int i = 0; i < NUM_Q; i++) begin
            if (sheet[i] == '0) expB++;
            else if (sheet[i] == modelKey[i]) expC++;
            else expW++;
         end
         checkOutput("readyDropsAtLast", ifA.ans_ready, 0);
         checkOutput("doneNotYet", doneA, 0);
         @(posedge clk); #1;
         checkOutput("doneA", doneA, 1);
         checkOutput("busyClear", busyA, 0);
         checkOutput("correctA", correctA, expC);
         checkOutput("wrongA", wrongA, expW);
         checkOutput("blankA", blankA, expB);
         checkOutput("scoreA", scoreA, clampScore(expC, expW, 1, 1));
         checkOutput("doneB", doneB, 1);
         checkOutput("correctB", correctB, expC);
         checkOutput("scoreB", scoreB, clampScore(expC, expW, POS_B, 1));
         repeat (2) @(posedge clk);
         #1;
         checkOutput("doneHeld", doneA, 1);
      end
   endtask

   task automatic randomSheet();
      for (int q = 0; q < NUM_Q; q++) begin
         case ($urandom_range(3, 0))
            0: sheet[q] = '0;
            1: sheet[q] = modelKey[q];
            2: sheet[q] = OPT_W'(1 << $urandom_range(OPT_W - 1, 0));
            default: sheet[q] = OPT_W'($urandom);
         endcase
      end
   endtask

   task automatic randomKey();
      for (int q = 0; q < NUM_Q; q++) begin
         sheet[q] = ($urandom_range(7, 0) == 0) ? '0 : OPT_W'(1 << $urandom_range(OPT_W - 1, 0));
      end
   endtask

   task automatic fixedKey();
      for (int q = 0; q < NUM_Q; q++) sheet[q] = OPT_W'(1 << (q % 4));
   endtask

   initial begin
      for (int i = 0; i < NUM_Q; i++) modelKey[i] = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkIdleAfterReset();

      gradeStart = 1'b1;
      @(posedge clk); #1;
      gradeStart = 1'b0;
      checkOutput("gradeNoKeyBusy", busyA, 0);
      checkOutput("gradeNoKeyReady", ifA.ans_ready, 0);

      beatValid = 1'b1;
      beatData = 4'hF;
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("idleBeatReady", ifA.ans_ready, 0);
      end
      beatValid = 1'b0;

      fixedKey();
      applyStimulus(1'b1, 1'b0, 1'b0, -1, -1);
      fixedKey();
      applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);
      checkOutput("perfectCorrect", correctA, 10);
      checkOutput("perfectScore", scoreA, 10);
      checkOutput("perfectSatB", scoreB, 255);

      for (int q = 0; q < NUM_Q; q++)
         sheet[q] = (q < 3) ? modelKey[q] : ((modelKey[q] == 4'd8) ? 4'd1 : OPT_W'(modelKey[q] << 1));
      applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);
      checkOutput("floorScore", scoreA, 0);

      fixedKey();
      sheet[7] = 4'd1;
      sheet[8] = 4'b0011;
      sheet[9] = 4'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);
      checkOutput("mixedScore", scoreA, 5);
      checkOutput("mixedBlank", blankA, 1);
      checkOutput("multiMarkWrong", wrongA, 2);
      checkOutput("mixedScoreB", scoreB, 208);

      for (int n = 0; n < 12; n++) begin
         if (n % 4 == 3) begin
            randomKey();
            applyStimulus(1'b1, 1'b1, 1'b0, -1, -1);
         end
         randomSheet();
         applyStimulus(1'b0, 1'b1, 1'b0, (n % 3 == 0) ? int'($urandom_range(NUM_Q - 1, 0)) : -1, -1);
      end

      randomKey();
      applyStimulus(1'b1, 1'b0, 1'b1, -1, -1);
      randomSheet();
      applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);

      randomSheet();
      applyStimulus(1'b0, 1'b1, 1'b0, -1, 4);
      gradeStart = 1'b1;
      @(posedge clk); #1;
      gradeStart = 1'b0;
      checkOutput("gradeAfterRstBusy", busyA, 0);
      checkOutput("gradeAfterRstReady", ifA.ans_ready, 0);

      fixedKey();
      applyStimulus(1'b1, 1'b0, 1'b0, -1, -1);
      randomSheet();
      applyStimulus(1'b0, 1'b1, 1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/omr_stream_grader.md
# omr_stream_grader

Clocked, parametrised successor to the combinational OMR scorer. It loads an answer key of NUM_Q questions over a one-beat-per-question valid/ready stream and stores it. It then grades any number of student sheets presented on the same stream against that key, and reports correct, wrong and blank counts plus a negatively-marked, zero-floored score. It sits between the sheet-reader front end and the result/display logic.

## Interface
- NUM_Q, 10: questions per sheet, ≥1
- OPT_W, 4: bits per answer (one-hot option bubbles)
- POS_MARK, 1: marks added per correct answer
- NEG_MARK, 1: marks deducted per wrong answer
- SCORE_W, 8: score output width
- CNT_W, derived $clog2(NUM_Q+1): counter width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- key_load  in  1  pulse: begin loading a new key
- grade_start  in  1  pulse: begin grading one sheet
- ans_valid  in  1  beat valid (key or student answer)
- ans_data  in  OPT_W  answer bits for the current question, question 0 first
- ans_ready  out  1  block accepts a beat
- key_loaded  out  1  a complete key is stored
- busy  out  1  in LOAD or GRADE
- done  out  1  result valid; held until the next accepted command
- correct_cnt, wrong_cnt, blank_cnt  out  CNT_W  per-sheet tallies
- score  out  SCORE_W  final score

## Operation
- States: IDLE, LOAD, GRADE, DONE.
- A beat is accepted when ans_valid && ans_ready. ans_ready = 1 only in LOAD and GRADE.
- IDLE/DONE + key_load → LOAD. The question index is cleared, key_loaded drops to 0 and done drops to 0.
- IDLE/DONE + grade_start with key_loaded=1 → GRADE. Index and tallies are cleared and done drops to 0. grade_start is ignored if key_loaded=0.
- If key_load and grade_start arrive in the same cycle, key_load wins.
- Both commands are ignored while busy.
- In LOAD, an accepted beat writes ans_data to key[idx] and idx increments. The beat with idx=NUM_Q-1 sets key_loaded=1 and the state returns to IDLE.
- In GRADE, each accepted beat is classified against key[idx]:
  - blank: ans_data == 0 → blank_cnt+1, no penalty.
  - correct: ans_data == key[idx] → correct_cnt+1.
  - wrong: anything else, including multi-marked answers → wrong_cnt+1.
- After the beat with idx=NUM_Q-1 → DONE.
- Score is computed on entry to DONE. Let raw = correct_cnt·POS_MARK − wrong_cnt·NEG_MARK, computed signed and wide enough to be exact.
  - raw < 0 → score = 0.
  - raw > 2^SCORE_W−1 → score = 2^SCORE_W−1 (saturate).
  - Otherwise score = raw.
- Invariant in DONE: correct_cnt + wrong_cnt + blank_cnt = NUM_Q.
- The key persists across sheets until reset or the next key_load.
- Key entries are not validated. A key entry of 0 matches only blank answers, and a blank answer is classed blank first.

## Timing
- Reset, applied synchronously at any time including mid-LOAD or mid-GRADE, gives:
  - state IDLE
  - key array 0 and key_loaded 0
  - idx 0 and all tallies 0
  - score 0, done 0, busy 0, ans_ready 0
- Commands are sampled on a clock edge. busy and ans_ready rise in the cycle after that edge.
- Throughput is one beat per cycle, and ans_valid may be held high continuously.
- The tally update is registered on the accepting edge.
- Latency: if the last grade beat is accepted at edge N, then done=1 and score/counts are valid after edge N+1, and ans_ready=0 after edge N.
- Gaps in ans_valid stall progress with no timeout.
- Beats presented while ans_ready=0 are dropped, not buffered.

## Structure
- Package omr_pkg holds:
  - the state enum {IDLE, LOAD, GRADE, DONE}
  - the answer classification enum {BLANK, CORRECT, WRONG}
  - a count-width function shared with the display block.
- Sub-module omr_key_store is an NUM_Q×OPT_W register array with one synchronous write port, an asynchronous read port addressed by idx, and synchronous clear on reset.
- Classification, tallies, score arithmetic and FSM live in the top module.

## Test plan
- Perfect sheet (defaults): load key 1,2,4,8,1,2,4,8,1,2, then grade the identical sheet → correct 10, wrong 0, blank 0, score 10, done one cycle after the last beat.
- Negative floor: grade the same key with 3 correct, 7 wrong → score 0. With 7 correct, 2 wrong, 1 blank (ans 0) → score 5, blank_cnt 1.
- Multi-mark and saturation: answer 4'b0011 against key 1 → counted wrong. With POS_MARK=30, SCORE_W=8 and 10 correct → score 255.
- Handshake: toggle ans_valid randomly during GRADE → same tallies as the back-to-back run. A beat offered in IDLE is not consumed.
- Command rules:
  - grade_start before any key → stays IDLE.
  - key_load and grade_start in the same cycle → LOAD.
  - grade_start during GRADE → ignored.
  - Two consecutive sheets on one key → correct independent results.
- Reset mid-GRADE after 5 beats → all outputs 0 and key_loaded 0 next cycle. A subsequent grade_start is ignored until the key is reloaded.
